// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch: sequential RIB fetches (one outstanding) fill a Depth-entry {instr, pc} FIFO
// ahead of decode; jumps and JTAG resets flush the FIFO and discard any in-flight response.
module instr_prefetch_buf #(
   parameter int unsigned          AddrWidth = 32,
   parameter int unsigned          DataWidth = 32,
   parameter int unsigned          Depth     = 4,
   parameter logic [AddrWidth-1:0] BootAddr  = '0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   output logic                   rib_pc_req_o,
   output logic [AddrWidth-1:0]   rib_pc_addr_o,
   input  logic                   rib_pc_ready_i,
   input  logic [DataWidth-1:0]   rib_pc_data_i,
   input  logic                   jump_flag_i,
   input  logic [AddrWidth-1:0]   jump_addr_i,
   input  logic                   jtag_reset_flag_i,
   input  logic                   hold_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [DataWidth-1:0]   instr_o,
   output logic [AddrWidth-1:0]   pc_o,
   output logic [AddrWidth-1:0]   pc_next_o,
   output logic [$clog2(Depth):0] count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned CmpW = CntW + 1;
   localparam logic [AddrWidth-1:0] BootPc = {BootAddr[AddrWidth-1:2], 2'b00};

   logic [AddrWidth-1:0] fetch_pc_q, fetch_pc_d;
   logic                 req_q, req_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic                 discard_q, discard_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [DataWidth-1:0] instr_mem_q [Depth];
   logic [AddrWidth-1:0] pc_mem_q [Depth];

   logic                 flush, resp, push, pop, still_pending, credit_ok;
   logic [AddrWidth-1:0] flush_pc;
   logic                 unused_jump_lsbs;

   assign unused_jump_lsbs = ^jump_addr_i[1:0];

   always_comb begin
      flush         = jump_flag_i | jtag_reset_flag_i;
      flush_pc      = jtag_reset_flag_i ? BootPc : {jump_addr_i[AddrWidth-1:2], 2'b00};
      resp          = req_q & rib_pc_ready_i;
      still_pending = req_q & ~rib_pc_ready_i;
      push          = resp & ~discard_q & ~flush;
      pop           = valid_o & ready_i & ~flush;
      credit_ok     = (CmpW'(count_q) + CmpW'(req_q)) < CmpW'(Depth);

      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      req_d      = 1'b0;
      addr_d     = addr_q;

      if (flush) begin
         fetch_pc_d = flush_pc;
         discard_d  = still_pending;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (resp) begin
            discard_d = 1'b0;
            if (!discard_q) begin
               fetch_pc_d = fetch_pc_q + AddrWidth'(4);
            end
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         count_d = count_q + CntW'(push) - CntW'(pop);
      end

      // A flush empties the FIFO, so its target can be requested in the flush cycle itself
      if (still_pending) begin
         req_d = 1'b1;
      end else if (!hold_i && (flush || credit_ok)) begin
         req_d  = 1'b1;
         addr_d = fetch_pc_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_pc_q <= BootPc;
         req_q      <= 1'b0;
         addr_q     <= BootPc;
         discard_q  <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         discard_q  <= discard_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            instr_mem_q[i] <= '0;
            pc_mem_q[i]    <= '0;
         end
      end else if (push) begin
         instr_mem_q[wr_ptr_q] <= rib_pc_data_i;
         pc_mem_q[wr_ptr_q]    <= addr_q;
      end
   end

   assign rib_pc_req_o  = req_q;
   assign rib_pc_addr_o = addr_q;
   assign valid_o       = (count_q != '0);
   assign instr_o       = instr_mem_q[rd_ptr_q];
   assign pc_o          = pc_mem_q[rd_ptr_q];
   assign pc_next_o     = pc_o + AddrWidth'(4);
   assign count_o       = count_q;

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Bench for instr_prefetch_buf: bus responder with configurable wait states, a scoreboard of
// expected {instr, pc} pops built from the sequential-fetch/flush rules, directed scenarios, random soak.
module tb_instr_prefetch_buf;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] BOOT  = 32'h100;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   logic        clk, rst_n;
   logic        rib_pc_req, rib_pc_ready;
   logic [31:0] rib_pc_addr, rib_pc_data;
   logic        jump_flag, jtag_flag, hold, valid, ready;
   logic [31:0] jump_addr, instr, pc, pc_next;
   logic [2:0]  count;
   logic        flush_in;

   instr_prefetch_buf #(
      .AddrWidth(AW), .DataWidth(DW), .Depth(DEPTH), .BootAddr(BOOT)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .rib_pc_req_o(rib_pc_req), .rib_pc_addr_o(rib_pc_addr),
      .rib_pc_ready_i(rib_pc_ready), .rib_pc_data_i(rib_pc_data),
      .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
      .jtag_reset_flag_i(jtag_flag), .hold_i(hold),
      .valid_o(valid), .ready_i(ready),
      .instr_o(instr), .pc_o(pc), .pc_next_o(pc_next), .count_o(count)
   );

   assign flush_in = jump_flag | jtag_flag;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned n_pops   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] bus_data(input logic [31:0] a);
      return 32'hA0 + ((a - BOOT) >> 2);
   endfunction

   // ---------------- bus responder ----------------
   int unsigned bus_lat  = 0;
   bit          bus_rand = 0;
   int unsigned wcnt     = 0;
   bit          outstanding = 0;
   int unsigned req_cyc  = 0;
   int unsigned resp_cnt = 0;
   logic [31:0] last_resp_addr = '0;

   initial begin
      rib_pc_ready = 1'b0;
      rib_pc_data  = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            rib_pc_ready = 1'b0;
            outstanding  = 0;
         end else begin
            #1;
            if (rib_pc_req && rst_n) begin
               if (!outstanding) begin
                  wcnt    = bus_rand ? $urandom_range(0, 3) : bus_lat;
                  req_cyc = cyc;
               end
               if (wcnt == 0) begin
                  rib_pc_ready   = 1'b1;
                  rib_pc_data    = bus_data(rib_pc_addr);
                  outstanding    = 0;
                  resp_cnt++;
                  last_resp_addr = rib_pc_addr;
               end else begin
                  rib_pc_ready = 1'b0;
                  rib_pc_data  = $urandom;
                  wcnt--;
                  outstanding  = 1;
               end
            end else begin
               rib_pc_ready = 1'b0;
               outstanding  = 0;
            end
         end
      end
   end

   // ---------------- reference model / scoreboard producer ----------------
   // Fetches after a flush run target, target+4, ...; responses to requests presented
   // no later than the last flush (or reset) are never delivered to decode.
   entry_t      exp_q[$];
   logic [31:0] exp_fetch = BOOT;
   int unsigned last_flush_cyc = 0;

   initial begin : scoreboard
      entry_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            exp_fetch      = BOOT;
            last_flush_cyc = cyc;
         end else if (flush_in) begin
            exp_q.delete();
            exp_fetch      = jtag_flag ? BOOT : {jump_addr[31:2], 2'b00};
            last_flush_cyc = cyc;
         end else if (rib_pc_req && rib_pc_ready && req_cyc > last_flush_cyc) begin
            chk("fetch_addr", rib_pc_addr, exp_fetch);
            e.instr = bus_data(rib_pc_addr);
            e.pc    = rib_pc_addr;
            exp_q.push_back(e);
            exp_fetch = exp_fetch + 32'd4;
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      entry_t      e;
      bit          prev_stall = 0;
      bit          prev_hold  = 0;
      logic [31:0] prev_addr  = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (valid && ready && !flush_in) begin
               n_pops++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL pop_unexpected: got pc 0x%0h, expected no valid entry", pc);
               end else begin
                  e = exp_q.pop_front();
                  chk("pop_instr", instr, e.instr);
                  chk("pop_pc", pc, e.pc);
                  chk("pop_pc_next", pc_next, e.pc + 32'd4);
               end
            end
            if (prev_stall) begin
               chk("req_stable", 32'(rib_pc_req), 32'd1);
               chk("addr_stable", rib_pc_addr, prev_addr);
            end
            if (prev_hold && !prev_stall) chk("hold_no_issue", 32'(rib_pc_req), 32'd0);
            chk("addr_align", 32'(rib_pc_addr[1:0]), 32'd0);
            chk("count_le_depth", 32'(count <= DEPTH), 32'd1);
            prev_stall = rib_pc_req && !rib_pc_ready;
            prev_addr  = rib_pc_addr;
            prev_hold  = hold;
         end else begin
            prev_stall = 0;
            prev_hold  = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      resp_cnt = 0;
      rst_n = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"}, 32'(rib_pc_req), 32'd0);
      chk({tag, "_addr"}, rib_pc_addr, BOOT);
      chk({tag, "_valid"}, 32'(valid), 32'd0);
      chk({tag, "_instr"}, instr, 32'd0);
      chk({tag, "_pc"}, pc, 32'd0);
      chk({tag, "_pc_next"}, pc_next, 32'd4);
      chk({tag, "_count"}, 32'(count), 32'd0);
   endtask

   task automatic wait_req_addr(input logic [31:0] a, input int unsigned limit);
      bit ok = 0;
      for (int unsigned i = 0; i < limit; i++) begin
         @(negedge clk);
         if (rib_pc_req && rib_pc_addr == a) begin
            ok = 1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_req: no request to 0x%0h, expected within %0d cycles", a, limit);
      end
   endtask

   task automatic wait_valid(input int unsigned limit);
      bit ok = 0;
      for (int unsigned i = 0; i < limit; i++) begin
         @(negedge clk);
         if (valid) begin
            ok = 1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_valid: valid_o stayed 0, expected 1 within %0d cycles", limit);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios + soak ----------------
   initial begin : main
      int unsigned r;
      bit          hit;
      rst_n = 1'b0; ready = 1'b0; hold = 1'b0;
      jump_flag = 1'b0; jtag_flag = 1'b0; jump_addr = '0;

      step();
      chk_reset_vals("rst");

      // boot with zero-wait bus and an always-ready decoder
      ready = 1'b1; bus_lat = 0;
      rst_n = 1'b1;
      @(negedge clk); chk("boot_req_c0", 32'(rib_pc_req), 32'd0);
      step(); @(negedge clk);
      chk("boot_req_c1", 32'(rib_pc_req), 32'd1);
      chk("boot_addr_c1", rib_pc_addr, 32'h100);
      chk("boot_valid_c1", 32'(valid), 32'd0);
      step(); @(negedge clk);
      chk("boot_valid_c2", 32'(valid), 32'd1);
      chk("boot_pc_c2", pc, 32'h100);
      chk("boot_instr_c2", instr, 32'hA0);
      chk("boot_addr_c2", rib_pc_addr, 32'h104);
      step(); @(negedge clk);
      chk("boot_pc_c3", pc, 32'h104);
      chk("boot_instr_c3", instr, 32'hA1);
      repeat (4) step();

      // full backpressure
      ready = 1'b0;
      do_reset();
      repeat (12) step();
      @(negedge clk);
      chk("bp_count", 32'(count), 32'd4);
      chk("bp_req_dropped", 32'(rib_pc_req), 32'd0);
      chk("bp_fetches", resp_cnt, 32'd4);
      chk("bp_last_addr", last_resp_addr, 32'h10C);
      chk("bp_head_pc", pc, 32'h100);
      step(); ready = 1'b1;
      step(); ready = 1'b0;
      @(negedge clk);
      chk("bp_count_after_pop", 32'(count), 32'd3);
      step(); @(negedge clk);
      chk("bp_refetch_req", 32'(rib_pc_req), 32'd1);
      chk("bp_refetch_addr", rib_pc_addr, 32'h110);
      step(); @(negedge clk);
      chk("bp_refill_count", 32'(count), 32'd4);

      // jump while a request is pending
      ready = 1'b1; bus_lat = 3;
      do_reset();
      wait_req_addr(32'h108, 60);
      r = cyc;
      step(); jump_flag = 1'b1; jump_addr = 32'h2002;
      step(); jump_flag = 1'b0;
      @(negedge clk);
      chk("jp_valid", 32'(valid), 32'd0);
      chk("jp_count", 32'(count), 32'd0);
      chk("jp_req_kept", 32'(rib_pc_req), 32'd1);
      chk("jp_addr_kept", rib_pc_addr, 32'h108);
      wait_req_addr(32'h2000, 20);
      chk("jp_redirect_cycle", cyc, r + 4);
      wait_valid(20);
      chk("jp_first_pc", pc, 32'h2000);

      // jump coincident with a bus response
      bus_lat = 1;
      do_reset();
      repeat (4) step();
      hit = 0;
      for (int unsigned i = 0; i < 10 && !hit; i++) begin
         step();
         if (rib_pc_ready) hit = 1;
      end
      chk("jc_found_resp", 32'(hit), 32'd1);
      jump_flag = 1'b1; jump_addr = 32'h300;
      step(); jump_flag = 1'b0;
      @(negedge clk);
      chk("jc_req", 32'(rib_pc_req), 32'd1);
      chk("jc_addr", rib_pc_addr, 32'h300);
      chk("jc_count", 32'(count), 32'd0);
      chk("jc_valid", 32'(valid), 32'd0);
      step(); step(); @(negedge clk);
      chk("jc_valid_n3", 32'(valid), 32'd1);
      chk("jc_pc_n3", pc, 32'h300);
      chk("jc_instr_n3", instr, bus_data(32'h300));

      // JTAG reset and jump together
      bus_lat = 0;
      do_reset();
      repeat (5) step();
      jtag_flag = 1'b1; jump_flag = 1'b1; jump_addr = 32'h400;
      step(); jtag_flag = 1'b0; jump_flag = 1'b0;
      @(negedge clk);
      chk("jt_addr", rib_pc_addr, 32'h100);
      chk("jt_valid", 32'(valid), 32'd0);
      step(); @(negedge clk);
      chk("jt_pc", pc, 32'h100);

      // asynchronous reset mid-fetch
      bus_lat = 5;
      do_reset();
      wait_req_addr(32'h100, 10);
      step(); #1 rst_n = 1'b0;
      #1 chk_reset_vals("mid");
      step(); step();
      rst_n = 1'b1;
      @(negedge clk); chk("mid_req_c0", 32'(rib_pc_req), 32'd0);
      step(); @(negedge clk);
      chk("mid_req_c1", 32'(rib_pc_req), 32'd1);
      chk("mid_addr_c1", rib_pc_addr, BOOT);
      wait_valid(20);
      chk("mid_first_pc", pc, BOOT);

      // random soak
      bus_rand = 1;
      do_reset();
      n_pops = 0;
      for (int unsigned i = 0; i < 3000; i++) begin
         step();
         ready     = ($urandom_range(0, 3) != 0);
         hold      = ($urandom_range(0, 9) == 0);
         jtag_flag = ($urandom_range(0, 199) == 0);
         jump_flag = ($urandom_range(0, 29) == 0);
         jump_addr = $urandom;
      end
      step();
      ready = 1'b1; hold = 1'b0; jtag_flag = 1'b0; jump_flag = 1'b0;
      repeat (20) step();
      chk("soak_pops", 32'(n_pops > 500), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
